// File: rtl/calc_seq.sv
// W-bit accumulator ALU with valid/ready command port; optional shift-add MUL under `CALC_MUL_EN.
// Latency: one cycle for every op except MUL, which strobes its result W cycles after accept.
// Backpressure: cmd_ready drops only while a MUL iterates; results are a strobe with no backpressure.
module calc_seq #(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_ovf,
    output logic         res_zero,
    output logic         res_err
);
    localparam logic [2:0] OP_CLR  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    logic [W-1:0] accA;
    logic [W:0]   addFull;
    logic [W:0]   subFull;
    logic [W-1:0] aluRes;
    logic         aluOvf;
    logic         aluErr;
    logic         mulStart;
    logic         mulDone;
    logic [W-1:0] mulRes;
    logic         mulOvf;
    logic         cmdFire;

    assign addFull = {1'b0, accA} + {1'b0, cmd_data};
    assign subFull = {1'b0, accA} - {1'b0, cmd_data};
    assign cmdFire = cmd_valid && cmd_ready;

    always_comb begin
        aluRes   = accA;
        aluOvf   = 1'b0;
        aluErr   = 1'b0;
        mulStart = 1'b0;
        case (cmd_op)
            OP_CLR:  aluRes = '0;
            OP_LOAD: aluRes = cmd_data;
            OP_ADD:  begin aluRes = addFull[W-1:0]; aluOvf = addFull[W]; end
            OP_SUB:  begin aluRes = subFull[W-1:0]; aluOvf = subFull[W]; end
            OP_AND:  aluRes = accA & cmd_data;
            OP_OR:   aluRes = accA | cmd_data;
            OP_XOR:  aluRes = accA ^ cmd_data;
            default: begin
`ifdef CALC_MUL_EN
                mulStart = 1'b1;
`else
                aluErr = 1'b1;
`endif
            end
        endcase
    end

`ifdef CALC_MUL_EN
    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t         state, stateNext;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prodNext;

    // multiplier walks LSB-first while the multiplicand shifts up to match
    assign prodNext = prod + (mplier[0] ? mcand : '0);
    assign mulRes   = prodNext[W-1:0];
    assign mulOvf   = |prodNext[2*W-1:W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else begin
            state <= stateNext;
            if (state == ST_IDLE && cmd_valid && cmd_op == OP_MUL) begin
                cnt    <= '0;
                mcand  <= {{W{1'b0}}, accA};
                mplier <= cmd_data;
                prod   <= '0;
            end else if (state == ST_MUL) begin
                cnt    <= cnt + 1'b1;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                prod   <= prodNext;
            end
        end
    end

    always_comb begin
        stateNext = state;
        cmd_ready = 1'b0;
        mulDone   = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && cmd_op == OP_MUL) stateNext = ST_MUL;
            end
            ST_MUL: begin
                if (cnt == CW'(W - 1)) begin
                    mulDone   = 1'b1;
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end
`else
    assign cmd_ready = 1'b1;
    assign mulDone   = 1'b0;
    assign mulRes    = '0;
    assign mulOvf    = 1'b0;
`endif

    // res_data is the accumulator itself: A only ever changes on a strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accA      <= '0;
            res_valid <= 1'b0;
            res_ovf   <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (mulDone) begin
                accA      <= mulRes;
                res_ovf   <= mulOvf;
                res_err   <= 1'b0;
                res_valid <= 1'b1;
            end else if (cmdFire && !mulStart) begin
                accA      <= aluRes;
                res_ovf   <= aluOvf;
                res_err   <= aluErr;
                res_valid <= 1'b1;
            end
        end
    end

    assign res_data = accA;
    assign res_zero = (accA == '0);

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: directed scenarios plus random command stream against an arithmetic model.
module tb_calc_seq;
    localparam int W = 8;
`ifdef CALC_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_ovf;
    logic         res_zero;
    logic         res_err;

    int total = 0;
    int bad   = 0;
    int unsigned modelA = 0;

    // command driven while a MUL is busy; must only be taken in the strobe cycle
    bit           holdV  = 1'b0;
    logic [2:0]   holdOp = 3'd0;
    logic [W-1:0] holdD  = '0;

    calc_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .res_valid(res_valid), .res_data(res_data),
        .res_ovf(res_ovf), .res_zero(res_zero), .res_err(res_err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void refOp(input int unsigned a, input logic [2:0] op, input int unsigned b,
                                  output int unsigned r, output bit ovf, output bit err);
        longint unsigned m;
        longint unsigned full;
        m   = 64'd1 << W;
        r   = a;
        ovf = 1'b0;
        err = 1'b0;
        case (op)
            3'd0: r = 0;
            3'd1: r = b;
            3'd2: begin full = longint'(a) + b; r = int'(full % m); ovf = (full >= m); end
            3'd3: begin r = int'((longint'(a) + m - b) % m); ovf = (a < b); end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: begin
                if (MulEn) begin
                    full = longint'(a) * b;
                    r    = int'(full % m);
                    ovf  = (full / m) != 0;
                end else begin
                    err = 1'b1;
                end
            end
        endcase
    endfunction

    // called at a falling edge; returns at the falling edge of the strobe cycle
    task automatic doCmd(input logic [2:0] op, input logic [W-1:0] d);
        int unsigned r;
        bit ovf, err;
        refOp(modelA, op, d, r, ovf, err);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        #1;
        checkVal("ready_at_issue", cmd_ready, 1);
        @(posedge clk);
        #1;
        if (op == 3'd7 && MulEn) begin
            cmd_valid = holdV;
            cmd_op    = holdOp;
            cmd_data  = holdD;
            for (int k = 1; k <= W; k++) begin
                @(negedge clk);
                checkVal("mul_busy_rdy", cmd_ready, 0);
                checkVal("mul_busy_vld", res_valid, 0);
                checkVal("mul_busy_dat", res_data, modelA);
            end
        end
        @(negedge clk);
        modelA = r;
        checkVal("res_vld", res_valid, 1);
        checkVal("res_dat", res_data, r);
        checkVal("res_ovf", res_ovf, ovf);
        checkVal("res_zero", res_zero, (r == 0));
        checkVal("res_err", res_err, err);
        checkVal("res_rdy", cmd_ready, 1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            checkVal("idle_vld", res_valid, 0);
            checkVal("idle_dat", res_data, modelA);
        end
    endtask

    // asynchronous reset asserted between edges; outputs checked before any clock edge
    task automatic doReset();
        cmd_valid = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checkVal("rst_vld", res_valid, 0);
        checkVal("rst_dat", res_data, 0);
        checkVal("rst_zero", res_zero, 1);
        checkVal("rst_rdy", cmd_ready, 1);
        checkVal("rst_ovf", res_ovf, 0);
        checkVal("rst_err", res_err, 0);
        modelA = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        repeat (2) @(negedge clk);
        doReset();
        idle(1);

        // ADD wrap, back-to-back
        doCmd(3'd1, 8'hF0);
        doCmd(3'd2, 8'h20);
        checkVal("addwrap_dat", res_data, 8'h10);
        checkVal("addwrap_ovf", res_ovf, 1);

        // SUB borrow, then ADD to zero
        doCmd(3'd1, 8'h05);
        doCmd(3'd3, 8'h06);
        checkVal("subborrow_dat", res_data, 8'hFF);
        doCmd(3'd2, 8'h01);
        checkVal("addzero_dat", res_data, 8'h00);
        checkVal("addzero_zero", res_zero, 1);

        // logic ops
        doCmd(3'd1, 8'hAA);
        doCmd(3'd4, 8'h0F);
        checkVal("and_dat", res_data, 8'h0A);
        doCmd(3'd5, 8'h50);
        checkVal("or_dat", res_data, 8'h5A);
        doCmd(3'd6, 8'h5A);
        checkVal("xor_zero", res_zero, 1);
        idle(2);

        doCmd(3'd1, 8'h10);
        if (MulEn) begin
            holdV = 1'b1; holdOp = 3'd1; holdD = 8'h33;
            doCmd(3'd7, 8'h11);
            checkVal("mul_dat", res_data, 8'h10);
            checkVal("mul_ovf", res_ovf, 1);
            holdV = 1'b0;
            doCmd(3'd1, 8'h33);
            doCmd(3'd1, 8'h0C);
            doCmd(3'd7, 8'h0A);
            checkVal("mul2_dat", res_data, 8'h78);
            checkVal("mul2_ovf", res_ovf, 0);
        end else begin
            doCmd(3'd7, 8'h03);
            checkVal("mulerr_err", res_err, 1);
            checkVal("mulerr_dat", res_data, 8'h10);
        end
        idle(1);

        // reset mid-stream
        doCmd(3'd1, 8'h5C);
        doReset();
        idle(2);

        if (MulEn) begin
            // abort a MUL four cycles in: no strobe may follow
            doCmd(3'd1, 8'h21);
            cmd_valid = 1'b1; cmd_op = 3'd7; cmd_data = 8'h07;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            repeat (4) @(negedge clk);
            doReset();
            idle(W + 2);
        end

        for (int i = 0; i < 300; i++) begin
            logic [2:0]   op;
            logic [W-1:0] d;
            op = 3'($urandom_range(0, 7));
            d  = W'($urandom_range(0, (1 << W) - 1));
            doCmd(op, d);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 49) == 0) doReset();
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
